// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide
// over operand magnitudes, with sign fix-up, start/busy/done handshake and HI/LO results.
module muldiv_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_MITER,
    S_DITER,
    S_FIX,
    S_DZERO
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic               op_div_q, op_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    mag_a     = (sgn_q && op_a_q[WIDTH-1]) ? -op_a_q : op_a_q;
    mag_b     = (sgn_q && op_b_q[WIDTH-1]) ? -op_b_q : op_b_q;
    mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? op_a_q : '0)};
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    prod      = {acc_hi_q, acc_lo_q};

    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    cnt_d      = cnt_q;
    sgn_d      = sgn_q;
    op_div_d   = op_div_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start_mult || start_div) begin
          op_a_d   = a;
          op_b_d   = b;
          sgn_d    = SIGNED_EN && is_signed;
          op_div_d = !start_mult;
          busy_d   = 1'b1;
          state_d  = (!start_mult && (b == '0)) ? S_DZERO : S_PREP;
        end
      end
      S_PREP: begin
        op_a_d   = mag_a;
        op_b_d   = mag_b;
        neg_q_d  = sgn_q && (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]);
        neg_r_d  = sgn_q && op_a_q[WIDTH-1];
        cnt_d    = '0;
        acc_hi_d = '0;
        acc_lo_d = op_div_q ? mag_a : mag_b;
        state_d  = op_div_q ? S_DITER : S_MITER;
      end
      S_MITER: begin
        // Add the multiplicand into the upper half, then shift the whole pair right.
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_DITER: begin
        // acc_lo shifts dividend bits out of the top and quotient bits in at the bottom.
        if (div_shift >= {1'b0, op_b_q}) begin
          acc_hi_d = div_shift[WIDTH-1:0] - op_b_q;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_div_q) begin
          lo_d = neg_q_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_r_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_q_q ? -prod : prod;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_DZERO: begin
        done_d     = 1'b1;
        div_zero_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      cnt_q      <= '0;
      sgn_q      <= 1'b0;
      op_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      cnt_q      <= cnt_d;
      sgn_q      <= sgn_d;
      op_div_q   <= op_div_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random operations checked
// against 64-bit integer arithmetic for product, quotient and remainder.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_mult = 1'b0;
  logic         start_div = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .is_signed(is_signed), .a(a), .b(b), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Result of one request per the architectural rules; hi/lo hold on divide-by-zero.
  function automatic void ref_op(input bit m, input bit s, input logic [31:0] x,
                                 input logic [31:0] y, inout logic [31:0] h,
                                 inout logic [31:0] l, output bit dz);
    longint sx, sy, r, q;
    longint unsigned ux, uy, ur;
    dz = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (m) begin
      if (s) begin
        r = sx * sy;
        h = r[63:32];
        l = r[31:0];
      end else begin
        ur = ux * uy;
        h = ur[63:32];
        l = ur[31:0];
      end
    end else if (y == 32'd0) begin
      dz = 1'b1;
    end else if (s) begin
      q = sx / sy;
      r = sx % sy;
      l = q[31:0];
      h = r[31:0];
    end else begin
      l = x / y;
      h = x % y;
    end
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'h8000_0000;
      3: v = 32'hFFFF_FFFF;
      4: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one request; inject > 0 pulses both starts with junk operands that many edges in.
  task automatic run_op(input bit m, input bit d, input bit s, input logic [31:0] x,
                        input logic [31:0] y, input string tag, input int inject);
    logic [31:0] eh, el;
    bit dz, got, busy_bad;
    int lat, n;
    eh = m_hi;
    el = m_lo;
    ref_op(m, s, x, y, eh, el, dz);
    lat = dz ? 1 : W + 2;
    @(negedge clk);
    start_mult = m; start_div = d; is_signed = s; a = x; b = y;
    @(posedge clk); #1;
    start_mult = 1'b0; start_div = 1'b0;
    chk({tag, " busy_on_accept"}, {63'b0, busy}, 64'd1);
    n = 0; got = 1'b0; busy_bad = 1'b0;
    while (!got && n < 100) begin
      if (inject > 0 && n == inject) begin
        start_mult = 1'b1; start_div = 1'b1; is_signed = ~s; a = $urandom; b = '0;
      end
      @(posedge clk); #1;
      n++;
      start_mult = 1'b0; start_div = 1'b0;
      if (done === 1'b1) got = 1'b1;
      else if (busy !== 1'b1) busy_bad = 1'b1;
    end
    chk({tag, " done_seen"}, {63'b0, got}, 64'd1);
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " busy_held"}, {63'b0, busy_bad}, 64'd0);
    chk({tag, " busy_at_done"}, {63'b0, busy}, 64'd0);
    chk({tag, " div_zero"}, {63'b0, div_zero}, {63'b0, dz});
    chk({tag, " hi"}, {32'b0, hi}, {32'b0, eh});
    chk({tag, " lo"}, {32'b0, lo}, {32'b0, el});
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    bit seen;
    logic [31:0] x, y;
    bit m, s;

    #1;
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset done", {63'b0, done}, 64'd0);
    chk("reset div_zero", {63'b0, div_zero}, 64'd0);
    chk("reset hi", {32'b0, hi}, 64'd0);
    chk("reset lo", {32'b0, lo}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    run_op(1, 0, 1, 32'hFFFF_FFFD, 32'd7, "smul_m3x7", 0);
    run_op(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umul_max", 0);
    run_op(0, 1, 1, 32'hFFFF_FFF9, 32'd2, "sdiv_m7d2", 0);
    run_op(0, 1, 0, 32'd100, 32'd7, "udiv_100d7", 0);
    run_op(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_minneg", 0);
    run_op(0, 1, 0, 32'h451, 32'h20, "udiv_setup", 0);
    chk("setup hi", {32'b0, hi}, 64'h11);
    chk("setup lo", {32'b0, lo}, 64'h22);
    run_op(0, 1, 1, 32'h1234, 32'h0, "div_by_zero", 0);
    @(posedge clk); #1;
    chk("dz done_one_cycle", {63'b0, done}, 64'd0);
    chk("dz div_zero_one_cycle", {63'b0, div_zero}, 64'd0);
    chk("dz busy_after", {63'b0, busy}, 64'd0);

    run_op(1, 1, 0, 32'd5, 32'd3, "both_starts", 0);
    run_op(1, 0, 1, 32'hFFFF_FF00, 32'h0000_1234, "ignore_starts", 5);
    run_op(0, 1, 1, 32'h7FFF_FFFF, 32'hFFFF_FFFD, "ignore_starts_div", 20);

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      x = pick();
      y = pick();
      run_op(m, !m, s, x, y, "random", 0);
    end

    // Mid-operation reset after a result with nonzero hi/lo.
    run_op(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "pre_reset", 0);
    @(negedge clk);
    start_mult = 1'b1; a = 32'h1357_9BDF; b = 32'h2468_ACE0; is_signed = 1'b0;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (11) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset busy", {63'b0, busy}, 64'd0);
    chk("midreset done", {63'b0, done}, 64'd0);
    chk("midreset hi", {32'b0, hi}, 64'd0);
    chk("midreset lo", {32'b0, lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk) reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("midreset no_done_after", {63'b0, seen}, 64'd0);
    run_op(0, 1, 0, 32'd9, 32'd0, "post_reset_dz", 0);
    run_op(1, 0, 1, 32'h8000_0000, 32'h8000_0000, "post_reset_mul", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the multicycle datapath. Driven by the control unit through a start/busy/done handshake, replacing the ad-hoc MultCtrl/MultOut and DivCtrl/DivOut/divZero signalling.
- Computes the full 2*WIDTH product, or the quotient and remainder, into HI/LO registers. Operand width and signed support are parametrised. Divide-by-zero is reported as an exception pulse.

Parameters:
- WIDTH, 32, operand width and width of each of hi/lo; must be at least 4.
- SIGNED_EN, 1, when 1 the is_signed input selects two's-complement mode; when 0 all operations are unsigned and is_signed is ignored.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start_mult  input  1  request a multiply; sampled only in IDLE.
- start_div  input  1  request a divide; sampled only in IDLE.
- is_signed  input  1  signed mode for the request; sampled together with start.
- a  input  WIDTH  multiplicand / dividend; sampled with start.
- b  input  WIDTH  multiplier / divisor; sampled with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; hi/lo are valid in the same cycle.
- div_zero  output  1  one-cycle pulse on a divide with b==0; coincides with done.
- hi  output  WIDTH  product upper half / remainder.
- lo  output  WIDTH  product lower half / quotient.

Behaviour:
- Reset (any time, including mid-operation): state=IDLE; busy, done, div_zero=0; hi=lo=0; all internal registers cleared.
- States: IDLE, PREP, MITER, DITER, FIX, DZERO.
- IDLE: start_mult has priority if both starts are high.
  - Either start -> capture a, b and mode; next state is PREP.
  - start_div with b==0 -> next state is DZERO instead.
  - Starts are ignored in every other state; there is no queueing.
- PREP (1 cycle): in signed mode, latch |a|, |b| and the result signs.
  - Quotient/product sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Clear the iteration counter. Go to MITER or DITER.
- MITER: radix-2 shift-add over unsigned magnitudes, one bit per cycle, exactly WIDTH cycles; then FIX.
- DITER: restoring division over unsigned magnitudes, one quotient bit per cycle, exactly WIDTH cycles; then FIX.
- FIX (1 cycle): apply sign correction and register hi/lo. done=1 during the cycle after FIX; next state is IDLE.
- DZERO (1 cycle): next edge goes to IDLE with done=1 and div_zero=1 for one cycle. hi/lo keep their previous values.
- Latency: done is high in the cycle after the (WIDTH+2)th rising edge following the edge that accepts start (34 edges for WIDTH=32). For divide-by-zero, done is high after the first edge.
- busy is high from the edge that accepts start until the edge that raises done, where it drops.
- A new start may be accepted in the same cycle done is high, because the FSM is in IDLE.
- Multiply: {hi,lo} = full 2*WIDTH product, signed or unsigned.
- Divide: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
- Signed most-negative / -1: lo = most-negative value, hi = 0; no exception.
- Unsigned mode: magnitudes are the raw operands and no sign correction is applied.
- hi/lo change only at FIX or on reset and hold between operations.

Test Plan:
- WIDTH=32, signed mult a=0xFFFFFFFD (-3), b=7 -> done at edge 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for edges 1..33.
- Unsigned mult a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned div a=100, b=7 -> lo=14, hi=2.
- After a completed op with hi=0x11, lo=0x22, issue div with b=0 -> done and div_zero pulse after 1 edge for exactly one cycle; hi=0x11, lo=0x22 unchanged; busy never high beyond that.
- Signed div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- start_mult and start_div together -> multiply performed. start pulses while busy -> ignored, result unchanged. reset low at iteration 10 -> busy=0, hi=lo=0 immediately, no done pulse afterwards.
